// File: rtl/mfp_ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite codes, data-phase select record and board address map
// for the MIPSfpga single-master interconnect.
package mfp_ahb_lite_interconnect_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Index field wide enough for the 16-slave maximum
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    typedef struct packed {
        logic             dflt;
        logic [IDX_W-1:0] idx;
    } dsel_t;

    localparam dsel_t DSEL_DEFAULT = '{dflt: 1'b1, idx: {IDX_W{1'b0}}};

    // Board map: 0 boot ROM, 1 RAM, 2 GPIO, 3 UART, 4 SPI (slave 0 in the low word)
    localparam int BOARD_N_SLAVES = 5;
    localparam logic [BOARD_N_SLAVES*32-1:0] BOARD_SLAVE_BASE =
        {32'h1F820000, 32'h1F810000, 32'h1F800000, 32'h00000000, 32'h1FC00000};
    localparam logic [BOARD_N_SLAVES*32-1:0] BOARD_SLAVE_MASK =
        {32'h1FFF0000, 32'h1FFF0000, 32'h1FFF0000, 32'h10000000, 32'h1FC00000};

    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_interconnect_if.sv
// AHB-Lite bus bundle between the core, the interconnect and the slaves.
// master: the core/slave environment side; slave: the interconnect side.
interface mfp_ahb_lite_interconnect_if #(
    parameter int N_SLAVES = 5
);
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [31:0]            HRDATA;
    logic                   HREADY;
    logic                   HRESP;
    logic [N_SLAVES-1:0]    S_HSEL;
    logic [N_SLAVES-1:0]    S_HREADYOUT;
    logic [N_SLAVES-1:0]    S_HRESP;
    logic [N_SLAVES*32-1:0] S_HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, S_HREADYOUT, S_HRESP, S_HRDATA,
        input  HRDATA, HREADY, HRESP, S_HSEL
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, S_HREADYOUT, S_HRESP, S_HRDATA,
        output HRDATA, HREADY, HRESP, S_HSEL
    );
endinterface

// File: rtl/mfp_ahb_lite_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers plus the
// exported error status (last errored address, saturating count, pulse).
module mfp_ahb_lite_default_slave
    import mfp_ahb_lite_interconnect_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 bus_ready,
    input  logic                 addr_hit,
    input  logic [1:0]           HTRANS,
    input  logic [31:0]          HADDR,
    output logic                 ds_hready,
    output logic                 ds_hresp,
    output logic [31:0]          ERR_ADDR,
    output logic [ERR_CNT_W-1:0] ERR_COUNT,
    output logic                 ERR_PULSE
);

    ds_state_e            state_r;
    ds_state_e            state_s;
    logic                 new_err_s;
    logic                 err_load_s;
    logic [31:0]          err_addr_r;
    logic [ERR_CNT_W-1:0] err_count_r;
    logic                 err_pulse_r;

    // FSM state register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r <= DS_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and default-slave response
    always_comb begin
        state_s    = state_r;
        ds_hready  = 1'b1;
        ds_hresp   = HRESP_OKAY;
        err_load_s = 1'b0;
        new_err_s  = bus_ready && !addr_hit && is_active(HTRANS);
        case (state_r)
            DS_IDLE: begin
                if (new_err_s) begin
                    state_s    = DS_ERR1;
                    err_load_s = 1'b1;
                end else begin
                    state_s = DS_IDLE;
                end
            end
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = HRESP_ERROR;
                state_s   = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp = HRESP_ERROR;
                if (new_err_s) begin
                    state_s    = DS_ERR1;
                    err_load_s = 1'b1;
                end else begin
                    state_s = DS_IDLE;
                end
            end
            default: begin
                state_s = DS_IDLE;
            end
        endcase
    end

    // Error status capture; counter sticks at all-ones
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            err_addr_r  <= 32'h0;
            err_count_r <= {ERR_CNT_W{1'b0}};
            err_pulse_r <= 1'b0;
        end else begin
            err_pulse_r <= err_load_s;
            if (err_load_s) begin
                err_addr_r <= HADDR;
                if (err_count_r != {ERR_CNT_W{1'b1}}) begin
                    err_count_r <= err_count_r + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign ERR_ADDR  = err_addr_r;
    assign ERR_COUNT = err_count_r;
    assign ERR_PULSE = err_pulse_r;

endmodule

// File: rtl/mfp_ahb_lite_interconnect.sv
// Single-master AHB-Lite decoder and response mux for N_SLAVES base/mask
// windows; HREADY comes from the data-phase owner only.
module mfp_ahb_lite_interconnect
    import mfp_ahb_lite_interconnect_pkg::*;
#(
    parameter int                      N_SLAVES   = 5,
    parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {N_SLAVES{32'h0}},
    parameter int                      ERR_CNT_W  = 8
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    mfp_ahb_lite_interconnect_if.slave bus,
    output logic [31:0]                ERR_ADDR,
    output logic [ERR_CNT_W-1:0]       ERR_COUNT,
    output logic                       ERR_PULSE
);

    logic                hit_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic [N_SLAVES-1:0] hsel_s;
    logic                win_s;
    dsel_t               dsel_s;
    dsel_t               dsel_r;
    logic                hready_s;
    logic                hresp_s;
    logic [31:0]         hrdata_s;
    logic                ds_hready_s;
    logic                ds_hresp_s;

    // Address decode; scanning downwards leaves the lowest matching index
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        win_s     = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            win_s = (SLAVE_MASK[i*32 +: 32] != 32'h0) &&
                    ((bus.HADDR & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
            hit_s     = win_s ? 1'b1 : hit_s;
            hit_idx_s = win_s ? IDX_W'(i) : hit_idx_s;
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            hsel_s[i] = hit_s && (hit_idx_s == IDX_W'(i));
        end
        dsel_s.dflt = !hit_s;
        dsel_s.idx  = hit_idx_s;
    end

    // Data-phase owner advances only when the current data phase completes
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel_r <= DSEL_DEFAULT;
        end else if (hready_s) begin
            dsel_r <= dsel_s;
        end
    end

    // Response mux: default slave unless a real slave owns the data phase
    always_comb begin
        hready_s = ds_hready_s;
        hresp_s  = ds_hresp_s;
        hrdata_s = 32'h0;
        for (int i = 0; i < N_SLAVES; i++) begin
            hready_s = (!dsel_r.dflt && dsel_r.idx == IDX_W'(i)) ? bus.S_HREADYOUT[i]    : hready_s;
            hresp_s  = (!dsel_r.dflt && dsel_r.idx == IDX_W'(i)) ? bus.S_HRESP[i]        : hresp_s;
            hrdata_s = (!dsel_r.dflt && dsel_r.idx == IDX_W'(i)) ? bus.S_HRDATA[i*32 +: 32] : hrdata_s;
        end
    end

    mfp_ahb_lite_default_slave #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus_ready (hready_s),
        .addr_hit  (hit_s),
        .HTRANS    (bus.HTRANS),
        .HADDR     (bus.HADDR),
        .ds_hready (ds_hready_s),
        .ds_hresp  (ds_hresp_s),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_COUNT (ERR_COUNT),
        .ERR_PULSE (ERR_PULSE)
    );

    assign bus.S_HSEL = hsel_s;
    assign bus.HREADY = hready_s;
    assign bus.HRESP  = hresp_s;
    assign bus.HRDATA = hrdata_s;

endmodule

// File: tb/tb_mfp_ahb_lite_interconnect.sv
// Bench for mfp_ahb_lite_interconnect: a master/slave driver pushes the
// expected data-phase response per accepted address phase; a monitor checks.
module tb_mfp_ahb_lite_interconnect;

    localparam int N     = 3;
    localparam int ERR_W = 8;
    localparam int CNT_MAX = (1 << ERR_W) - 1;
    localparam logic [N*32-1:0] BASES = {32'h1F800000, 32'h00000000, 32'h1FC00000};
    localparam logic [N*32-1:0] MASKS = {32'h1FC00000, 32'h10000000, 32'h1FC00000};
    localparam int K_SLAVE = 0;
    localparam int K_ERR   = 1;
    localparam int K_OKAY  = 2;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        int          waits;
        logic [31:0] data;
    } phase_t;

    typedef struct {
        int          kind;
        logic        write;
        int          waits;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic [31:0]      err_addr;
    logic [ERR_W-1:0] err_count;
    logic             err_pulse;

    int     checks = 0;
    int     failures = 0;
    phase_t dir_q[$];
    exp_t   exp_q[$];
    phase_t pres;
    bit     rand_en = 1'b0;
    bit     in_reset = 1'b1;
    bit     cur_valid = 1'b0;
    logic   acc = 1'b0;
    int     sl_owner = -1;
    int     sl_wait = 0;
    logic [31:0] sl_data = 32'h0;
    int     m_cnt = 0;
    logic [31:0] m_addr = 32'h0;

    mfp_ahb_lite_interconnect_if #(.N_SLAVES(N)) bus ();

    mfp_ahb_lite_interconnect #(
        .N_SLAVES   (N),
        .SLAVE_BASE (BASES),
        .SLAVE_MASK (MASKS),
        .ERR_CNT_W  (ERR_W)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .ERR_ADDR  (err_addr),
        .ERR_COUNT (err_count),
        .ERR_PULSE (err_pulse)
    );

    always #5 HCLK = ~HCLK;

    // Address map rule: first window (lowest index) whose masked compare matches
    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (MASKS[i*32 +: 32] != 32'h0 && (a & MASKS[i*32 +: 32]) == BASES[i*32 +: 32])
                return i;
        end
        return -1;
    endfunction

    function automatic phase_t mk(input logic [31:0] a, input logic [1:0] t, input logic w,
                                  input int waits, input logic [31:0] d);
        phase_t p;
        p.addr = a; p.trans = t; p.write = w; p.waits = waits; p.data = d;
        return p;
    endfunction

    function automatic phase_t rand_phase();
        logic [31:0] a;
        logic [1:0]  t;
        int          r;
        case ($urandom_range(0, 4))
            0: a = 32'h1FC00000 | ($urandom & 32'h003FFFFC);
            1: a = $urandom & 32'hEFFFFFFC;
            2: a = 32'h1F800000 | ($urandom & 32'h003FFFFC);
            3: a = 32'h1F000000 | ($urandom & 32'h007FFFFC);
            default: a = $urandom;
        endcase
        r = $urandom_range(0, 9);
        t = (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r == 7) ? 2'b00 : 2'b01;
        return mk(a, t, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive_bus();
        bus.HADDR  = pres.addr;
        bus.HTRANS = pres.trans;
        bus.HWRITE = pres.write;
        for (int j = 0; j < N; j++) begin
            if (j == sl_owner) begin
                bus.S_HREADYOUT[j]     = (sl_wait == 0);
                bus.S_HRESP[j]         = 1'b0;
                bus.S_HRDATA[j*32 +: 32] = (sl_wait == 0) ? sl_data : $urandom;
            end else begin
                bus.S_HREADYOUT[j]     = 1'($urandom_range(0, 1));
                bus.S_HRESP[j]         = 1'($urandom_range(0, 1));
                bus.S_HRDATA[j*32 +: 32] = $urandom;
            end
        end
    endtask

    // One bus cycle: account for the edge, drive the next inputs, sample HREADY
    task automatic step(input bit rst_req, input bit rst_on_err);
        exp_t e;
        int   m;
        bit   took_err;
        @(posedge HCLK);
        #1;
        took_err = 1'b0;
        if (!HRESETn) begin
            exp_q.delete();
            cur_valid = 1'b0;
            in_reset = 1'b1;
            m_cnt = 0;
            m_addr = 32'h0;
            sl_owner = -1;
            sl_wait = 0;
        end else begin
            in_reset = 1'b0;
            if (acc) begin
                m = ref_decode(bus.HADDR);
                e.addr = bus.HADDR;
                e.write = bus.HWRITE;
                e.data = pres.data;
                e.waits = 0;
                if (m >= 0) begin
                    e.kind = K_SLAVE;
                    e.waits = bus.HTRANS[1] ? pres.waits : 0;
                    sl_owner = m;
                    sl_wait = e.waits;
                    sl_data = pres.data;
                end else begin
                    e.kind = bus.HTRANS[1] ? K_ERR : K_OKAY;
                    took_err = bus.HTRANS[1];
                    sl_owner = -1;
                    sl_wait = 0;
                end
                exp_q.push_back(e);
                if (dir_q.size() > 0) pres = dir_q.pop_front();
                else if (rand_en) pres = rand_phase();
                else pres = mk(32'h1F000000, 2'b00, 1'b0, 0, 32'h0);
            end else if (sl_wait > 0) begin
                sl_wait--;
            end
        end
        drive_bus();
        HRESETn = !(rst_req || (rst_on_err && took_err));
        @(negedge HCLK);
        acc = bus.HREADY;
    endtask

    // Monitor: compares every cycle against the head expected data phase
    initial begin : monitor
        exp_t cur;
        int   c;
        int   m;
        logic [N-1:0] sel_exp;
        logic exp_rdy, exp_resp, exp_pulse;
        c = 0;
        forever begin
            @(negedge HCLK);
            m = ref_decode(bus.HADDR);
            sel_exp = '0;
            if (m >= 0) sel_exp[m] = 1'b1;
            chk("s_hsel", 32'(bus.S_HSEL), 32'(sel_exp));
            if (in_reset) begin
                chk("reset_hready", 32'(bus.HREADY), 32'd1);
                chk("reset_hresp", 32'(bus.HRESP), 32'd0);
                chk("reset_hrdata", bus.HRDATA, 32'h0);
                chk("reset_err_count", 32'(err_count), 32'd0);
                chk("reset_err_pulse", 32'(err_pulse), 32'd0);
                chk("reset_err_addr", err_addr, 32'h0);
            end else begin
                if (!cur_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard: got 0 pending data phases, expected 1 (t=%0t)", $time);
                    end else begin
                        cur = exp_q.pop_front();
                        c = 0;
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    exp_pulse = 1'b0;
                    case (cur.kind)
                        K_SLAVE: begin
                            exp_rdy = (c >= cur.waits);
                            exp_resp = 1'b0;
                            if (exp_rdy && !cur.write) chk("hrdata_slave", bus.HRDATA, cur.data);
                        end
                        K_ERR: begin
                            exp_rdy = (c >= 1);
                            exp_resp = 1'b1;
                            if (c == 0) begin
                                exp_pulse = 1'b1;
                                m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
                                m_addr = cur.addr;
                            end
                            chk("hrdata_default", bus.HRDATA, 32'h0);
                        end
                        default: begin
                            exp_rdy = 1'b1;
                            exp_resp = 1'b0;
                            chk("hrdata_okay", bus.HRDATA, 32'h0);
                        end
                    endcase
                    chk("hready", 32'(bus.HREADY), 32'(exp_rdy));
                    chk("hresp", 32'(bus.HRESP), 32'(exp_resp));
                    chk("err_pulse", 32'(err_pulse), 32'(exp_pulse));
                    chk("err_count", 32'(err_count), 32'(m_cnt));
                    chk("err_addr", err_addr, m_addr);
                    if (exp_rdy) cur_valid = 1'b0;
                    else c++;
                end
            end
        end
    end

    // Watchdog so a stuck HREADY still ends in a summary
    initial begin
        repeat (20000) @(posedge HCLK);
        failures++;
        $display("FAIL watchdog: got cycle budget exhausted, expected run to complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        pres = mk(32'h1F000000, 2'b00, 1'b0, 0, 32'h0);
        drive_bus();
        @(negedge HCLK);
        acc = bus.HREADY;
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // Directed: idle unmapped, waited slave-2 read, error, back-to-back slaves
        dir_q.push_back(mk(32'h1F000000, 2'b00, 1'b0, 0, 32'h0));
        dir_q.push_back(mk(32'h1F800004, 2'b10, 1'b0, 2, 32'hA5A5A5A5));
        dir_q.push_back(mk(32'h1F000000, 2'b10, 1'b0, 0, 32'h0));
        dir_q.push_back(mk(32'h1F000040, 2'b01, 1'b0, 0, 32'h0));
        dir_q.push_back(mk(32'h00001000, 2'b10, 1'b0, 0, 32'h11111111));
        dir_q.push_back(mk(32'h1F800010, 2'b10, 1'b0, 1, 32'h22222222));
        dir_q.push_back(mk(32'h1FC00020, 2'b11, 1'b0, 3, 32'h33333333));
        dir_q.push_back(mk(32'h00002000, 2'b10, 1'b0, 0, 32'h44444444));
        while (dir_q.size() > 0) step(1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0);

        // Back-to-back unmapped transfers run the counter into saturation
        for (int k = 0; k < CNT_MAX + 4; k++)
            dir_q.push_back(mk(32'h1F000000 + 32'(k * 4), 2'b10, 1'b0, 0, 32'h0));
        while (dir_q.size() > 0) step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // Reset lands while the default slave sits in ERR1
        dir_q.push_back(mk(32'h1F000100, 2'b10, 1'b0, 0, 32'h0));
        while (dir_q.size() > 0) step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        rand_en = 1'b1;
        repeat (600) step(1'b0, 1'b0);
        rand_en = 1'b0;
        repeat (8) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_lite_interconnect.md
Name: mfp_ahb_lite_interconnect

Overview:
Parametrised single-master AHB-Lite decoder and response multiplexer for N slaves, with per-slave base/mask address windows. It tracks address and data phase per the AHB-Lite protocol and routes HREADY from the selected slave only, rather than ANDing all slaves. An internal default slave returns a two-cycle ERROR for unmapped active transfers. Error status is exported for an interrupt and debug path. It sits between the MIPSfpga core AHB-Lite port and the RAM, GPIO, UART and SPI slaves.

Parameters:
N_SLAVES, 5, number of slave ports (1..16).
SLAVE_BASE, {N_SLAVES{32'h0}}, flattened N_SLAVES*32 vector; slave i matches when (HADDR & MASK_i) == BASE_i.
SLAVE_MASK, {N_SLAVES{32'h0}}, flattened N_SLAVES*32 vector of per-slave compare masks; a mask of 0 disables the slave.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
HCLK  in  1  system clock
HRESETn  in  1  reset, synchronous, active-low
HADDR  in  32  master address
HTRANS  in  2  master transfer type
HWRITE  in  1  master write flag
HRDATA  out  32  read data to master
HREADY  out  1  ready to master; also broadcast to slaves
HRESP  out  1  response to master (0 OKAY, 1 ERROR)
S_HSEL  out  N_SLAVES  address-phase select, one-hot or zero
S_HREADYOUT  in  N_SLAVES  per-slave ready
S_HRESP  in  N_SLAVES  per-slave response
S_HRDATA  in  N_SLAVES*32  per-slave read data; slave i occupies bits [32i+31:32i]
ERR_ADDR  out  32  address of the most recent errored transfer
ERR_COUNT  out  ERR_CNT_W  saturating count of default-slave errors
ERR_PULSE  out  1  one-cycle pulse on each default-slave error

Behaviour:
Clocking and reset:
- Single clock HCLK. Reset is synchronous, active-low, on HRESETn sampled at posedge HCLK.

Address decode (combinational):
- Slave i hits when MASK_i != 0 and (HADDR & MASK_i) == BASE_i.
- Overlapping hits: the lowest index wins. S_HSEL is the one-hot winner.
- S_HSEL is driven regardless of HTRANS; slaves qualify with HTRANS.
- No hit routes the transfer to the default slave.

Data-phase select register:
- dsel (index plus a "default" flag) loads the address-phase decode only on cycles with HREADY=1.
- It holds while HREADY=0, so wait states stretch the data phase correctly.

Response mux:
- When dsel is slave i: HREADY = S_HREADYOUT[i], HRESP = S_HRESP[i], HRDATA = S_HRDATA slice i.
- When dsel is default: HRDATA = 0; HREADY and HRESP come from the default-slave FSM.

Default slave FSM, states IDLE, ERR1, ERR2:
- IDLE: outputs HREADY=1, HRESP=0. If HREADY=1 and there is no hit and HTRANS is NONSEQ or SEQ, go to ERR1.
- IDLE with no hit and HTRANS IDLE or BUSY gives a zero-wait OKAY and no error.
- ERR1: outputs HREADY=0, HRESP=1; always go to ERR2.
- ERR2: outputs HREADY=1, HRESP=1. A new unmapped active transfer sampled this cycle goes to ERR1; otherwise go to IDLE.

Error status:
- On the ERR1 entry cycle, ERR_ADDR captures the registered address-phase HADDR.
- On the same cycle ERR_COUNT increments, saturating at all-ones, and ERR_PULSE is 1 in the following cycle (the ERR1 cycle).

Reset values:
- dsel = default, FSM = IDLE, HREADY=1, HRESP=0, HRDATA=0, ERR_ADDR=0, ERR_COUNT=0, ERR_PULSE=0.
- Reset asserted mid-transfer, including during ERR1 or ERR2, aborts to IDLE on the next edge.

Boundary cases:
- Back-to-back accesses to different slaves: slave A's data phase overlaps slave B's address phase. The response comes from A and S_HSEL selects B.
- A slave that inserts wait states freezes dsel and error capture.
- N_SLAVES=1 must elaborate.

Decomposition:
- Shared header mfp_ahb_lite.vh holds the HTRANS codes (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11) and HRESP codes (OKAY 0, ERROR 1).
- mfp_ahb_lite_matrix_config.vh supplies the SLAVE_BASE and SLAVE_MASK values for the board.
- One sub-module, mfp_ahb_lite_default_slave, contains the error FSM and the error status registers.

Test Plan:
- Reset, then idle bus -> HREADY=1, HRESP=0, HRDATA=0, ERR_COUNT=0, S_HSEL=0 when HADDR matches nothing.
- Config N=3: BASE0=0x1FC00000/MASK0=0x1FC00000, BASE1=0/MASK1=0x10000000, BASE2=0x1F800000/MASK2=0x1FC00000. NONSEQ read at 0x1F800004, slave 2 returns 0xA5A5A5A5 with HREADYOUT low for 2 cycles -> HREADY low 2 cycles, then HRDATA=0xA5A5A5A5. Slaves 0 and 1 HREADYOUT are ignored.
- NONSEQ at unmapped 0x1F000000 -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1; ERR_ADDR=0x1F000000, ERR_COUNT=1, ERR_PULSE high exactly one cycle.
- IDLE HTRANS at an unmapped address -> zero-wait OKAY, ERR_COUNT unchanged.
- Back-to-back reads slave 1 then slave 2 -> each data phase returns the correct slave's data; 2^ERR_CNT_W+3 unmapped errors -> ERR_COUNT saturates at all-ones.
- HRESETn low during ERR1 -> next cycle HREADY=1, HRESP=0, ERR_COUNT=0.
